// File: rtl/vga_mix_pkg.sv
// Shared types and constants for the VGA layer mixer.
// The colour struct packs {r,g,b}. inactive_level() gives the idle level of a sync line from its polarity.
package vga_mix_pkg;

  localparam int DEF_LAYER_CNT = 4;
  localparam int DEF_LAT       = 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  localparam color_t COLOR_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

  function automatic logic inactive_level(input logic pol);
    return ~pol;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with an asynchronous reset to RST_VAL.
// pre_o is the value about to enter the last stage, so one cycle ahead of data_o.
module sync_delay_line #(
  parameter int              DEPTH   = 1,
  parameter int              WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] pre_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[DEPTH-1];

  generate
    if (DEPTH == 1) begin : g_pre_direct
      assign pre_o = data_i;
    end else begin : g_pre_stage
      assign pre_o = stage_q[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/vga_layer_mixer.sv
// Fixed-priority compositor of LAYER_CNT renderer layers onto a background colour.
// Sync is realigned to the renderer latency; mask and blink settings change only at frame start.
module vga_layer_mixer
  import vga_mix_pkg::*;
#(
  parameter int LAYER_CNT = DEF_LAYER_CNT,
  parameter int DATA_W    = 24,
  parameter int LAT       = DEF_LAT,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int BLINK_W   = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          pix_hs_i,
  input  logic                          pix_vs_i,
  input  logic                          pix_de_i,
  input  logic [LAYER_CNT*DATA_W-1:0]   layer_data_i,
  input  logic [LAYER_CNT-1:0]          layer_en_i,
  input  logic [LAYER_CNT-1:0]          layer_mask_i,
  input  logic [LAYER_CNT-1:0]          layer_blink_i,
  input  logic [DATA_W-1:0]             bg_color_i,
  output logic                          vga_hs_o,
  output logic                          vga_vs_o,
  output logic                          vga_de_o,
  output logic [DATA_W-1:0]             vga_data_o,
  output logic                          frame_start_o,
  output logic [BLINK_W-1:0]            frame_cnt_o
);

  localparam logic [2:0] SYNC_RST = {inactive_level(HS_POL), inactive_level(VS_POL), 1'b0};

  logic [2:0]           sync_out;
  logic [2:0]           sync_pre;
  logic                 unused_sync_pre;
  logic                 vs_q;
  logic                 frame_edge;
  logic [LAYER_CNT-1:0] mask_sh;
  logic [LAYER_CNT-1:0] blink_sh;
  logic                 blink_phase;
  logic [LAYER_CNT-1:0] layer_vis;
  logic [DATA_W-1:0]    sel_color;

  sync_delay_line #(
    .DEPTH  (LAT + 1),
    .WIDTH  (3),
    .RST_VAL(SYNC_RST)
  ) u_sync_dly (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .data_i ({pix_hs_i, pix_vs_i, pix_de_i}),
    .data_o (sync_out),
    .pre_o  (sync_pre)
  );

  assign {vga_hs_o, vga_vs_o, vga_de_o} = sync_out;
  // Only the de tap is needed; it gates the colour entering the output register.
  assign unused_sync_pre = ^sync_pre[2:1];

  // Frame start is taken on the undelayed vs so shadows are ready before the first visible pixel.
  assign frame_edge = (pix_vs_i == VS_POL) && (vs_q != VS_POL);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vs_q          <= inactive_level(VS_POL);
      frame_start_o <= 1'b0;
      frame_cnt_o   <= '0;
      mask_sh       <= '1;
      blink_sh      <= '0;
    end else begin
      vs_q          <= pix_vs_i;
      frame_start_o <= frame_edge;
      if (frame_edge) begin
        frame_cnt_o <= frame_cnt_o + 1'b1;
        mask_sh     <= layer_mask_i;
        blink_sh    <= layer_blink_i;
      end
    end
  end

  assign blink_phase = frame_cnt_o[BLINK_W-1];
  assign layer_vis   = layer_en_i & mask_sh & ~(blink_sh & {LAYER_CNT{blink_phase}});

  // Walk from lowest to highest priority so layer 0 overrides everything else.
  always_comb begin
    sel_color = bg_color_i;
    for (int n = LAYER_CNT - 1; n >= 0; n--) begin
      if (layer_vis[n]) sel_color = layer_data_i[n*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) vga_data_o <= DATA_W'(COLOR_BLACK);
    else          vga_data_o <= sync_pre[0] ? sel_color : DATA_W'(COLOR_BLACK);
  end

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer: latency, priority, mask latching, blink, reset and vs polarity.
// Two instances: polarity-0 with LAT=1, and polarity-1 with LAT=3.
module tb_vga_layer_mixer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        pix_hs_i, pix_vs_i, pix_de_i, b_vs_i;
  logic [95:0] layer_data_i;
  logic [3:0]  layer_en_i, layer_mask_i, layer_blink_i;
  logic [23:0] bg_color_i;

  logic        a_hs, a_vs, a_de, a_fs;
  logic [23:0] a_data;
  logic [1:0]  a_cnt;
  logic        b_hs, b_vs, b_de, b_fs;
  logic [23:0] b_data;
  logic [1:0]  b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  vga_layer_mixer #(.LAYER_CNT(4), .DATA_W(24), .LAT(1), .HS_POL(1'b0), .VS_POL(1'b0), .BLINK_W(2)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pix_hs_i(pix_hs_i), .pix_vs_i(pix_vs_i), .pix_de_i(pix_de_i),
    .layer_data_i(layer_data_i), .layer_en_i(layer_en_i), .layer_mask_i(layer_mask_i),
    .layer_blink_i(layer_blink_i), .bg_color_i(bg_color_i), .vga_hs_o(a_hs), .vga_vs_o(a_vs),
    .vga_de_o(a_de), .vga_data_o(a_data), .frame_start_o(a_fs), .frame_cnt_o(a_cnt)
  );

  vga_layer_mixer #(.LAYER_CNT(4), .DATA_W(24), .LAT(3), .HS_POL(1'b1), .VS_POL(1'b1), .BLINK_W(2)) u_dut_pol (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pix_hs_i(pix_hs_i), .pix_vs_i(b_vs_i), .pix_de_i(pix_de_i),
    .layer_data_i(layer_data_i), .layer_en_i(layer_en_i), .layer_mask_i(layer_mask_i),
    .layer_blink_i(layer_blink_i), .bg_color_i(bg_color_i), .vga_hs_o(b_hs), .vga_vs_o(b_vs),
    .vga_de_o(b_de), .vga_data_o(b_data), .frame_start_o(b_fs), .frame_cnt_o(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Active-low vs pulse on the main instance, then let the data path settle.
  task automatic frame_pulse();
    pix_vs_i = 1'b0;
    tick();
    pix_vs_i = 1'b1;
    ticks(3);
  endtask

  logic [1:0]  blink_cnt_exp  [5] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [23:0] blink_data_exp [5] = '{24'hFF0000, 24'hFF0000, 24'h0000FF, 24'h0000FF, 24'hFF0000};

  initial begin
    rst_n_i       = 1'b0;
    pix_hs_i      = 1'b1;
    pix_vs_i      = 1'b1;
    pix_de_i      = 1'b0;
    b_vs_i        = 1'b0;
    layer_data_i  = {24'h123456, 24'h00FF00, 24'hFF0000, 24'h0000FF};
    layer_en_i    = 4'b0000;
    layer_mask_i  = 4'b1111;
    layer_blink_i = 4'b0000;
    bg_color_i    = 24'h202020;
    ticks(2);

    check("rst_hs", 32'(a_hs), 32'd1);
    check("rst_vs", 32'(a_vs), 32'd1);
    check("rst_de", 32'(a_de), 32'd0);
    check("rst_data", 32'(a_data), 32'h0);
    check("rst_fs", 32'(a_fs), 32'd0);
    check("rst_cnt", 32'(a_cnt), 32'd0);
    check("rst_pol_vs", 32'(b_vs), 32'd0);
    check("rst_pol_hs", 32'(b_hs), 32'd0);

    rst_n_i = 1'b1;
    ticks(10);

    // One-cycle de/hs pulse: lag 2 on the LAT=1 instance, lag 4 on LAT=3.
    pix_de_i = 1'b1;
    pix_hs_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      pix_de_i = 1'b0;
      pix_hs_i = 1'b1;
      check($sformatf("lat_de_%0d", k), 32'(a_de), 32'(k == 2));
      check($sformatf("lat_hs_%0d", k), 32'(a_hs), 32'(k != 2));
      check($sformatf("lat3_de_%0d", k), 32'(b_de), 32'(k == 4));
    end

    pix_de_i   = 1'b1;
    layer_en_i = 4'b0110;
    ticks(3);
    check("prio_l1", 32'(a_data), 32'hFF0000);
    layer_en_i = 4'b0000;
    ticks(3);
    check("prio_bg", 32'(a_data), 32'h202020);
    pix_de_i = 1'b0;
    ticks(3);
    check("prio_blank", 32'(a_data), 32'h0);
    pix_de_i = 1'b1;

    // A new mask applied mid-frame has no effect until vs goes active.
    layer_en_i   = 4'b0110;
    layer_mask_i = 4'b1101;
    ticks(3);
    check("mask_midframe", 32'(a_data), 32'hFF0000);
    pix_vs_i = 1'b0;
    tick();
    check("mask_fs_hi", 32'(a_fs), 32'd1);
    check("mask_cnt", 32'(a_cnt), 32'd1);
    tick();
    check("mask_fs_lo", 32'(a_fs), 32'd0);
    pix_vs_i = 1'b1;
    ticks(2);
    check("mask_l2", 32'(a_data), 32'h00FF00);
    check("mask_cnt_hold", 32'(a_cnt), 32'd1);

    layer_mask_i  = 4'b1111;
    layer_blink_i = 4'b0001;
    layer_en_i    = 4'b0111;
    for (int f = 0; f < 5; f++) begin
      frame_pulse();
      check($sformatf("blink_cnt_%0d", f), 32'(a_cnt), 32'(blink_cnt_exp[f]));
      check($sformatf("blink_data_%0d", f), 32'(a_data), 32'(blink_data_exp[f]));
    end

    // Active-high vs: only the rising edge starts a frame.
    b_vs_i = 1'b1;
    tick();
    check("pol_fs_rise", 32'(b_fs), 32'd1);
    check("pol_cnt_rise", 32'(b_cnt), 32'd1);
    tick();
    check("pol_fs_lo", 32'(b_fs), 32'd0);
    b_vs_i = 1'b0;
    tick();
    check("pol_fs_fall", 32'(b_fs), 32'd0);
    tick();
    check("pol_cnt_fall", 32'(b_cnt), 32'd1);

    rst_n_i = 1'b0;
    #1;
    check("mid_rst_de", 32'(a_de), 32'd0);
    check("mid_rst_data", 32'(a_data), 32'h0);
    check("mid_rst_hs", 32'(a_hs), 32'd1);
    check("mid_rst_vs", 32'(a_vs), 32'd1);
    check("mid_rst_cnt", 32'(a_cnt), 32'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    check("post_rst_fs", 32'(a_fs), 32'd0);
    pix_vs_i = 1'b0;
    tick();
    check("post_rst_fs_hi", 32'(a_fs), 32'd1);
    check("post_rst_cnt", 32'(a_cnt), 32'd1);
    pix_vs_i = 1'b1;
    ticks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_layer_mixer.md
Name: vga_layer_mixer

Overview:
- Parametrised N-layer pixel compositor between the VGA timing generator and the VGA output pins.
- Merges LAYER_CNT independent renderers (strings, field, next-block preview, overlays) by fixed priority onto a background colour.
- Realigns hs/vs/de to the renderers' pipeline latency.
- Adds per-layer runtime visibility masks and blink mode. Both are latched only at frame start so the picture never tears mid-frame.

Parameters:
- LAYER_CNT, 4, number of layer inputs; layer 0 has highest priority.
- DATA_W, 24, colour width, {R,G,B} packed.
- LAT, 1, renderer latency in clk_i cycles from pix_* inputs to layer_* inputs; range 0..15.
- HS_POL, 0, active level of hs.
- VS_POL, 0, active level of vs.
- BLINK_W, 5, blink half-period is 2^(BLINK_W-1) frames.

Ports:
- clk_i  in  1  pixel clock
- rst_n_i  in  1  asynchronous active-low reset
- pix_hs_i  in  1  hs from timing generator
- pix_vs_i  in  1  vs from timing generator
- pix_de_i  in  1  display enable from timing generator
- layer_data_i  in  LAYER_CNT*DATA_W  layer n colour at [n*DATA_W +: DATA_W]
- layer_en_i  in  LAYER_CNT  layer n hit flag, aligned with layer_data_i
- layer_mask_i  in  LAYER_CNT  requested visibility (1 = visible)
- layer_blink_i  in  LAYER_CNT  requested blink mode
- bg_color_i  in  DATA_W  colour used where no layer hits
- vga_hs_o  out  1  aligned hs
- vga_vs_o  out  1  aligned vs
- vga_de_o  out  1  aligned de
- vga_data_o  out  DATA_W  composited colour
- frame_start_o  out  1  one-cycle pulse at each frame start
- frame_cnt_o  out  BLINK_W  frame counter, wraps

Behaviour:
- Reset values (async, rst_n_i low):
  - vga_hs_o = ~HS_POL; vga_vs_o = ~VS_POL; vga_de_o = 0; vga_data_o = 0.
  - frame_start_o = 0; frame_cnt_o = 0.
  - Shadow mask = all 1; shadow blink = all 0.
  - All delay stages reset to their inactive level.
- Sync path: hs/vs/de pass through a shift register of depth LAT+1. Output sync therefore lags pix_* by exactly LAT+1 cycles.
- Data path: layer_data_i/layer_en_i are LAT cycles behind pix_*. The colour is selected combinationally and registered once, so it lags by LAT+1 and aligns with the sync outputs.
- Selection: pick the lowest n with layer_en_i[n] & mask_sh[n] & ~(blink_sh[n] & blink_phase). If no layer qualifies, output bg_color_i.
- Blanking: if the de value entering the output register is 0, vga_data_o is forced to 0 regardless of layers.
- Frame start: detected when the registered pix_vs_i changes from inactive to the VS_POL level, on the pix_vs_i side before the delay line. The first active edge after reset counts. In that cycle:
  - mask_sh <= layer_mask_i and blink_sh <= layer_blink_i.
  - frame_cnt increments, wrapping from 2^BLINK_W-1 to 0.
  - frame_start_o pulses high for one cycle, registered.
- Changes to layer_mask_i or layer_blink_i at any other time are ignored until the next frame start.
- blink_phase = frame_cnt[BLINK_W-1]. Blinking layers are hidden while the phase is 1.
- A layer with mask 0 is never shown, even if blink is set.
- Reset mid-frame: all outputs return to reset values immediately. Normal operation resumes on the next clock after release. Shadow registers keep their reset values until the first frame start.
- LAT = 0: the delay line has depth 1 and layer inputs are aligned with pix_*.

Decomposition:
- Package vga_mix_pkg:
  - colour typedef (DATA_W-wide {r,g,b}).
  - COLOR_BLACK constant.
  - Default LAYER_CNT/LAT constants.
  - Function for polarity-aware inactive levels.
- Sub-module sync_delay_line: parameters DEPTH, WIDTH and RST_VAL. Asynchronous active-low reset. Instantiated once for the {hs,vs,de} bundle.

Test Plan:
- Latency: LAT=1, HS_POL=VS_POL=0. Pulse pix_de_i high at cycle 10 -> vga_de_o high at cycle 12 only. vga_hs_o/vga_vs_o track pix_* with the same 2-cycle lag. With LAT=3 the lag is 4.
- Priority: layer_en_i=4'b0110, data1=24'hFF0000, data2=24'h00FF00, de=1, mask all 1 -> vga_data_o=24'hFF0000. en=0 -> bg_color_i (24'h202020). de=0 -> 24'h000000.
- Mask latch: drive layer_mask_i=4'b1101 mid-frame -> layer 1 still shown. After the next vs falling edge, frame_start_o pulses once, layer 1 is hidden and layer 2's colour appears.
- Blink: BLINK_W=2, layer_blink_i[0]=1, layer 0 always hits -> layer 0 is visible for frames 0-1 and hidden for frames 2-3 (lower-priority layer or bg shown). Pattern repeats after frame_cnt_o wraps 3 -> 0.
- Reset: assert rst_n_i mid-line with de=1 -> outputs immediately go de=0, data=0, hs=vs=1, frame_cnt_o=0. After release, the first vs edge pulses frame_start_o.
- Polarity: VS_POL=1. A rising pix_vs_i edge is the frame start and a falling edge is not. vga_vs_o resets to 0.
